// File: rtl/ser_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package ser_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } ser_rx_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/ser_rx_shifter.sv
// Bidirectional WIDTH-bit shift register with synchronous active-low clear.
// shreg_next is the value the register takes at the next edge.
module ser_rx_shifter
    import ser_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             ser_in,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (shift_en) begin
            if (dir == DIR_LSB_FIRST) begin
                shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], ser_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign shreg_next = shreg_d;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with valid/ack handshake and sticky overrun.
// Optional even-parity bit and parity_err output when SER_RX_PARITY_EN is defined.
module serial_word_rx
    import ser_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             ser_in,
    input  logic             start,
    input  logic             dir,
    input  logic             ack,
    output logic [WIDTH-1:0] A_par,
    output logic             valid,
    output logic             busy,
    output logic             overrun
`ifdef SER_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    ser_rx_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] a_par_q, a_par_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
`ifdef SER_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic             shift_en;
    logic             shift_dir;
    logic [WIDTH-1:0] shreg_next;

    ser_rx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk        (CLK),
        .clear_b    (Clear_b),
        .shift_en   (shift_en),
        .dir        (shift_dir),
        .ser_in     (ser_in),
        .shreg_next (shreg_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        a_par_d   = a_par_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        shift_en  = 1'b0;
        shift_dir = dir_q;
`ifdef SER_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_en  = 1'b1;
                    shift_dir = dir;
                    dir_d     = dir;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef SER_RX_PARITY_EN
                    state_d = PARITY;
`else
                    a_par_d = shreg_next;
                    valid_d = 1'b1;
                    state_d = HOLD;
`endif
                end
            end

            PARITY: begin
`ifdef SER_RX_PARITY_EN
                // Shifter is idle here, so shreg_next is the completed word.
                a_par_d      = shreg_next;
                parity_err_d = (^shreg_next) ^ ser_in;
                valid_d      = 1'b1;
                state_d      = HOLD;
`else
                state_d = IDLE;
`endif
            end

            HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
`ifdef SER_RX_PARITY_EN
                    parity_err_d = 1'b0;
`endif
                    if (start) begin
                        shift_en  = 1'b1;
                        shift_dir = dir;
                        dir_d     = dir;
                        cnt_d     = CW'(WIDTH - 1);
                        state_d   = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Clear_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= DIR_MSB_FIRST;
            a_par_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SER_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            a_par_q   <= a_par_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef SER_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign A_par   = a_par_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == SHIFT) || (state_q == PARITY);
`ifdef SER_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed testbench for serial_word_rx at WIDTH=4; also covers SER_RX_PARITY_EN builds.
module tb_serial_word_rx;

    logic       CLK;
    logic       Clear_b;
    logic       ser_in;
    logic       start;
    logic       dir;
    logic       ack;
    logic [3:0] A_par;
    logic       valid;
    logic       busy;
    logic       overrun;
`ifdef SER_RX_PARITY_EN
    logic       parity_err;
`endif

    int tests_run;
    int tests_failed;

    serial_word_rx #(
        .WIDTH (4)
    ) dut (
        .CLK     (CLK),
        .Clear_b (Clear_b),
        .ser_in  (ser_in),
        .start   (start),
        .dir     (dir),
        .ack     (ack),
        .A_par   (A_par),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
`ifdef SER_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // bits[3] is sent first; an even-parity bit follows in parity builds.
    task automatic send_frame(input logic d, input logic [3:0] bits);
        start  = 1'b1;
        dir    = d;
        ser_in = bits[3];
        tick();
        start = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            ser_in = bits[i];
            tick();
        end
`ifdef SER_RX_PARITY_EN
        ser_in = ^bits;
        tick();
`endif
        ser_in = 1'b0;
    endtask

    task automatic test_reset();
        Clear_b = 1'b0;
        start = 1'b0; ack = 1'b0; dir = 1'b0; ser_in = 1'b0;
        tick();
        tick();
        tests_run++;
        if (A_par !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_A_par: got %b expected 0000", A_par); end
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef SER_RX_PARITY_EN
        tests_run++;
        if (parity_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
        Clear_b = 1'b1;
        tick();
    endtask

    task automatic test_msb_first();
        start = 1'b1; dir = 1'b0; ser_in = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL msb_busy_after_start: got %b expected 1", busy); end
        ser_in = 1'b0; tick();
        ser_in = 1'b1; tick();
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL msb_valid_early: got %b expected 0", valid); end
        ser_in = 1'b1; tick();
`ifdef SER_RX_PARITY_EN
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL msb_valid_before_parity: got %b expected 0", valid); end
        ser_in = 1'b1; tick();
`endif
        ser_in = 1'b0;
        tests_run++;
        if (valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL msb_valid: got %b expected 1", valid); end
        tests_run++;
        if (A_par !== 4'b1011) begin tests_failed++; $display("[TB] FAIL msb_A_par: got %b expected 1011", A_par); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL msb_busy_hold: got %b expected 0", busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (valid !== 1'b1 || A_par !== 4'b1011) begin
                tests_failed++;
                $display("[TB] FAIL msb_hold_%0d: got valid=%b A_par=%b expected valid=1 A_par=1011", i, valid, A_par);
            end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL msb_ack_valid: got %b expected 0", valid); end
        tests_run++;
        if (A_par !== 4'b1011) begin tests_failed++; $display("[TB] FAIL msb_ack_A_par: got %b expected 1011", A_par); end
    endtask

    task automatic test_lsb_first();
        send_frame(1'b1, 4'b1011);
        tests_run++;
        if (valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL lsb_valid: got %b expected 1", valid); end
        tests_run++;
        if (A_par !== 4'b1101) begin tests_failed++; $display("[TB] FAIL lsb_A_par: got %b expected 1101", A_par); end
        ack = 1'b1; tick(); ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL lsb_ack_valid: got %b expected 0", valid); end
    endtask

    task automatic test_overrun();
        send_frame(1'b0, 4'b1011);
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_before: got %b expected 0", overrun); end
        start = 1'b1; tick(); start = 1'b0;
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
        tests_run++;
        if (A_par !== 4'b1011 || valid !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovr_word_kept: got A_par=%b valid=%b busy=%b expected 1011 1 0", A_par, valid, busy);
        end
        ack = 1'b1; start = 1'b1; dir = 1'b0; ser_in = 1'b0;
        tick();
        ack = 1'b0; start = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovr_restart: got valid=%b busy=%b expected 0 1", valid, busy);
        end
        ser_in = 1'b1; tick();
        ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
`ifdef SER_RX_PARITY_EN
        ser_in = 1'b0; tick();
`endif
        tests_run++;
        if (valid !== 1'b1 || A_par !== 4'b0110) begin
            tests_failed++;
            $display("[TB] FAIL ovr_second_word: got valid=%b A_par=%b expected 1 0110", valid, A_par);
        end
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_start_ignored();
        start = 1'b1; ack = 1'b1; dir = 1'b1; ser_in = 1'b0;
        tick();
        dir = 1'b0; ser_in = 1'b0; tick();
        ser_in = 1'b1; tick();
        ser_in = 1'b1; tick();
        start = 1'b0; ack = 1'b0;
`ifdef SER_RX_PARITY_EN
        ser_in = 1'b0; tick();
`endif
        ser_in = 1'b0;
        tests_run++;
        if (valid !== 1'b1 || A_par !== 4'b1100) begin
            tests_failed++;
            $display("[TB] FAIL ignore_start_word: got valid=%b A_par=%b expected 1 1100", valid, A_par);
        end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1; dir = 1'b0; ser_in = 1'b1; tick();
        start = 1'b0; ser_in = 1'b0; tick();
        Clear_b = 1'b0; ser_in = 1'b1; tick();
        Clear_b = 1'b1;
        tests_run++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_state: got busy=%b valid=%b expected 0 0", busy, valid);
        end
        tests_run++;
        if (A_par !== 4'b0000) begin tests_failed++; $display("[TB] FAIL midrst_A_par: got %b expected 0000", A_par); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_overrun: got %b expected 0", overrun); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midrst_idle_%0d: got valid=%b busy=%b expected 0 0", i, valid, busy);
            end
        end
        ser_in = 1'b0;
    endtask

`ifdef SER_RX_PARITY_EN
    task automatic test_parity();
        send_frame(1'b0, 4'b1011);
        tests_run++;
        if (valid !== 1'b1 || parity_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL par_good: got valid=%b parity_err=%b expected 1 0", valid, parity_err);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        start = 1'b1; dir = 1'b0; ser_in = 1'b1; tick();
        start = 1'b0;
        ser_in = 1'b0; tick();
        ser_in = 1'b1; tick();
        ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
        tests_run++;
        if (valid !== 1'b1 || parity_err !== 1'b1 || A_par !== 4'b1011) begin
            tests_failed++;
            $display("[TB] FAIL par_bad: got valid=%b parity_err=%b A_par=%b expected 1 1 1011", valid, parity_err, A_par);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || parity_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL par_clear: got valid=%b parity_err=%b expected 0 0", valid, parity_err);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Clear_b = 1'b0;
        start   = 1'b0;
        ack     = 1'b0;
        dir     = 1'b0;
        ser_in  = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_start_ignored();
        test_reset_mid_frame();
`ifdef SER_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel word receiver: the receiving end of the serial link driven by the team's universal shift register in shift mode. It samples one bit per clock on `ser_in` after a `start` strobe, assembles a WIDTH-bit word MSB-first or LSB-first, and presents it on `A_par` with a valid/ack handshake. It sits between a serial shifter output and any parallel consumer.

## Interface

- `WIDTH`, default 4: word length in bits, minimum 2.
- `CLK`  in  1  clock; all state updates on rising edge.
- `Clear_b`  in  1  one clock; reset is synchronous and active-low.
- `ser_in`  in  1  serial data bit, sampled every rising edge while receiving.
- `start`  in  1  frame start; `ser_in` in the same cycle is data bit 0.
- `dir`  in  1  0 = MSB first (shift left), 1 = LSB first (shift right); sampled only with `start`.
- `ack`  in  1  consumer accepts the word; meaningful only while `valid`=1.
- `A_par`  out  WIDTH  received word, registered.
- `valid`  out  1  `A_par` holds a complete unacknowledged word.
- `busy`  out  1  frame reception in progress.
- `overrun`  out  1  sticky; a `start` was lost because a word was pending.
- `parity_err`  out  1  present only with `SER_RX_PARITY_EN`; see Configuration.

## Operation

- States: IDLE, SHIFT, PARITY (macro only), HOLD.
- Reset (`Clear_b`=0 at an edge): state IDLE; `A_par`=0, `valid`=0, `busy`=0, `overrun`=0, `parity_err`=0, shift register and counter cleared. Reset mid-frame discards the partial word; `A_par` still goes to 0.
- IDLE: `start`=1 -> latch `dir`, shift in `ser_in`, counter = WIDTH-1, go SHIFT. Otherwise stay.
- SHIFT: each edge shifts in `ser_in` and decrements the counter. The edge that takes the last bit (counter was 1) copies the assembled word to `A_par`, sets `valid`, and goes HOLD.
  - dir=0: shreg <= {shreg[WIDTH-2:0], ser_in}. First bit ends in MSB.
  - dir=1: shreg <= {ser_in, shreg[WIDTH-1:1]}. First bit ends in LSB.
  - `start` during SHIFT is ignored; no restart.
- HOLD: `A_par` stable.
  - `ack`=1 -> clear `valid`, go IDLE.
  - `ack`=1 and `start`=1 together -> clear `valid`, begin a new frame: go SHIFT with bit 0 captured. No overrun.
  - `start`=1 without `ack` -> set `overrun`; frame dropped; stay HOLD.
- `ack` outside HOLD is ignored.
- `busy`=1 exactly in SHIFT and PARITY.
- `overrun` clears only on reset.

## Timing

- `start` at edge 0 -> data bits sampled at edges 0..WIDTH-1 -> `valid`=1 and `A_par` updated after edge WIDTH-1. Latency: WIDTH cycles from `start` to visible `valid`.
- With the parity macro, the parity bit is sampled at edge WIDTH; `valid` is visible after that edge (WIDTH+1 cycles).
- `ack` at edge k -> `valid`=0 after edge k.
- Minimum frame spacing: WIDTH cycles with a same-cycle ack/start; otherwise WIDTH+1.

## Configuration

- `SER_RX_PARITY_EN` defined:
  - One extra PARITY state samples an even-parity bit on `ser_in` after the last data bit.
  - `parity_err` is registered together with `valid`: 1 if the XOR of data and parity bits is 1.
  - `parity_err` is held through HOLD and cleared with `valid`.
- Undefined: no PARITY state, no `parity_err` port, and frames are WIDTH bits.

## Structure

- Package `ser_rx_pkg`:
  - state typedef `ser_rx_state_t` {IDLE, SHIFT, PARITY, HOLD};
  - constants `DIR_MSB_FIRST`=1'b0 and `DIR_LSB_FIRST`=1'b1.
- Sub-module `ser_rx_shifter`: the WIDTH-bit bidirectional shift register with clear, shift-enable and direction inputs.
- The FSM, counter and output registers stay in `serial_word_rx`.

## Test plan

All scenarios use WIDTH=4.

- Reset: hold `Clear_b`=0 for 2 edges mid-idle -> `A_par`=0000, `valid`=`busy`=`overrun`=0.
- MSB first: `start` with dir=0, bits 1,0,1,1 -> `A_par`=1011, `valid`=1 after the 4th edge, held 5 cycles until `ack` -> `valid`=0 next edge.
- LSB first: dir=1, bits 1,0,1,1 -> `A_par`=1101.
- Overrun: word 1011 pending, `start` without `ack` -> `overrun`=1, `A_par` stays 1011. Then `ack`+`start` together with bits 0,1,1,0 -> `A_par`=0110, no new overrun event.
- Reset mid-frame: `Clear_b`=0 at bit 2 -> state IDLE, `busy`=0, `valid` never asserts, `A_par`=0000.
- Parity (macro): data 1011 with parity 1 -> `parity_err`=0; data 1011 with parity 0 -> `parity_err`=1; `valid` asserts 5 cycles after `start`.
